pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl_if.sv | 12 +
 rtl/pwm_fade_ctrl.sv | 135 +++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_ctrl_if.sv
// Request channel for pwm_fade_ctrl: valid/ready handshake carrying one
// per-channel duty fade command (channel, target duty, step rate).
interface pwm_fade_ctrl_if;
  logic       reqValid;
  logic       reqReady;
  logic [1:0] reqChannel;
  logic [7:0] reqTarget;
  logic [3:0] reqRate;

  modport master (output reqValid, reqChannel, reqTarget, reqRate, input reqReady);
  modport slave  (input reqValid, reqChannel, reqTarget, reqRate, output reqReady);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM duty fader: walks each channel's duty toward its target once per step
// and strobes the PWM load input. Define PWM_FADE_GAMMA_EN for squared (gamma) duty output.
module pwm_fade_ctrl #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned STEP_CYCLES = 1000
) (
  input  logic              masterClk,
  input  logic              reset,
  pwm_fade_ctrl_if.slave    req,
  output logic [NCH*8-1:0]  controlOut,
  output logic [NCH-1:0]    loadOut,
  output logic [NCH-1:0]    busy
);
  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_idx;
  logic [7:0]     r_cur  [NCH];
  logic [7:0]     r_tgt  [NCH];
  logic [7:0]     r_ctrl [NCH];
  logic [3:0]     r_rate [NCH];
  logic [NCH-1:0] r_init;
  logic [NCH-1:0] r_load;

  logic       w_tick, w_accept, w_chan_ok, w_visit;
  logic [7:0] w_cur, w_tgt, w_new;
  logic [3:0] w_rate;
  logic [8:0] w_sum, w_diff;

  function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef PWM_FADE_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(c) * 16'(c);
    shape = 8'(sq >> 8);
    if (shape == '0 && c != '0) shape = 8'd1;
`else
    shape = c;
`endif
  endfunction

  assign w_tick      = (r_cnt == CW'(STEP_CYCLES - 1));
  assign req.reqReady = (r_state == IDLE) && !w_tick && !reset;
  assign w_accept    = req.reqValid && req.reqReady;
  assign w_chan_ok   = ({1'b0, req.reqChannel} < 3'(NCH));

  always_ff @(posedge masterClk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge masterClk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= (r_state == SCAN) ? r_idx + 2'd1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_visit     = 1'b0;
    case (r_state)
      IDLE: if (w_tick) w_state_nxt = SCAN;
      SCAN: begin
        w_visit = 1'b1;
        if (r_idx == 2'(NCH - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Step arithmetic is one bit wider so overshoot/underflow clamps to target instead of wrapping.
  always_comb begin
    w_cur  = r_cur[r_idx];
    w_tgt  = r_tgt[r_idx];
    w_rate = r_rate[r_idx];
    w_sum  = {1'b0, w_cur} + {5'b0, w_rate};
    w_diff = {1'b0, w_cur} - {5'b0, w_rate};
    w_new  = w_cur;
    if (w_cur != w_tgt) begin
      if (w_rate == '0)
        w_new = w_tgt;
      else if (w_cur < w_tgt)
        w_new = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[7:0];
      else
        w_new = (w_diff[8] || (w_diff[7:0] < w_tgt)) ? w_tgt : w_diff[7:0];
    end
  end

  always_ff @(posedge masterClk) begin
    if (reset) begin
      r_load <= '0;
      r_init <= '1;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_cur[i]  <= '0;
        r_tgt[i]  <= '0;
        r_rate[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      r_load <= '0;
      if (w_accept && w_chan_ok) begin
        r_tgt[req.reqChannel]  <= req.reqTarget;
        r_rate[req.reqChannel] <= req.reqRate;
      end
      if (w_visit && (w_new != w_cur || r_init[r_idx])) begin
        r_cur[r_idx]  <= w_new;
        r_ctrl[r_idx] <= shape(w_new);
        r_load[r_idx] <= 1'b1;
        r_init[r_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    controlOut = '0;
    busy       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      controlOut[8*i +: 8] = r_ctrl[i];
      busy[i]              = (r_cur[i] != r_tgt[i]);
    end
  end

  assign loadOut = r_load;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl (NCH=4, STEP_CYCLES=10) with a cycle-indexed
// behavioural model: step ticks, scans and strobes are derived from the cycle count since reset.
module tb_pwm_fade_ctrl;
  localparam int NCH  = 4;
  localparam int STEP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] controlOut;
  logic [3:0]  loadOut;
  logic [3:0]  busy;
  int          checks   = 0;
  int          failures = 0;

  pwm_fade_ctrl_if ifc ();

  pwm_fade_ctrl #(.NCH(NCH), .STEP_CYCLES(STEP)) dut (
    .masterClk  (clk),
    .reset      (rst),
    .req        (ifc.slave),
    .controlOut (controlOut),
    .loadOut    (loadOut),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference state: m_k is the cycle index since reset release.
  int         m_k;
  int         m_cur [4];
  int         m_tgt [4];
  int         m_rate[4];
  bit         m_init[4];
  logic [7:0] m_ctrl[4];
  logic [3:0] m_load;

  function automatic logic [7:0] shape(input int c);
`ifdef PWM_FADE_GAMMA_EN
    int g;
    g = (c * c) / 256;
    if (g == 0 && c != 0) g = 1;
    return 8'(g);
`else
    return 8'(c);
`endif
  endfunction

  function automatic bit m_ready();
    int ph;
    ph = m_k % STEP;
    return !(ph == STEP - 1 || (m_k >= STEP && ph < NCH));
  endfunction

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) e[8*i +: 8] = m_ctrl[i];
    return e;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_cur[i] != m_tgt[i]);
    return e;
  endfunction

  function automatic void model_reset();
    m_k    = 0;
    m_load = '0;
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_init[i] = 1'b1; m_ctrl[i] = '0;
    end
  endfunction

  // Called at a negedge: drives one cycle of request inputs, advances across the posedge,
  // updates the model, and returns at the next negedge.
  task automatic step(input logic v, input logic [1:0] ch, input logic [7:0] t,
                      input logic [3:0] r, output logic acc);
    int ph, nv;
    ph = m_k % STEP;
    ifc.reqValid   = v;
    ifc.reqChannel = ch;
    ifc.reqTarget  = t;
    ifc.reqRate    = r;
    acc = v && m_ready();
    @(posedge clk);
    m_load = '0;
    if (acc) begin
      m_tgt[ch]  = t;
      m_rate[ch] = r;
    end
    if (m_k >= STEP && ph < NCH && (m_init[ph] || m_cur[ph] != m_tgt[ph])) begin
      if (m_cur[ph] == m_tgt[ph])     nv = m_cur[ph];
      else if (m_rate[ph] == 0)       nv = m_tgt[ph];
      else if (m_cur[ph] < m_tgt[ph]) nv = (m_cur[ph] + m_rate[ph] < m_tgt[ph]) ? m_cur[ph] + m_rate[ph] : m_tgt[ph];
      else                            nv = (m_cur[ph] - m_rate[ph] > m_tgt[ph]) ? m_cur[ph] - m_rate[ph] : m_tgt[ph];
      m_cur[ph]  = nv;
      m_ctrl[ph] = shape(nv);
      m_load[ph] = 1'b1;
      m_init[ph] = 1'b0;
    end
    m_k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    ifc.reqValid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (loadOut !== 4'h0) begin failures++; $display("FAIL rst_load got=%h exp=0", loadOut); end
    checks++; if (controlOut !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", controlOut); end
    checks++; if (busy !== 4'h0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy); end
    checks++; if (ifc.reqReady !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ifc.reqReady); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    logic [3:0] e;
    int n;
    do_reset();
    checks++; if (ifc.reqReady !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", ifc.reqReady); end
    n = 0;
    for (int i = 0; i < 25; i++) begin
      e = (m_k >= 11 && m_k <= 14) ? 4'(1 << (m_k - 11)) : 4'h0;
      checks++; if (loadOut !== e) begin failures++; $display("FAIL init_load k=%0d got=%h exp=%h", m_k, loadOut, e); end
      checks++; if (controlOut !== 32'h0) begin failures++; $display("FAIL init_ctrl k=%0d got=%h exp=0", m_k, controlOut); end
      n += $countones(loadOut);
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL init_strobe_count got=%0d exp=4", n); end
  endtask

  task automatic test_jump();
    logic acc;
    bit seen;
    int n;
    acc = 1'b0; n = 0; seen = 0;
    while (!acc && n < 20) begin step(1'b1, 2'd1, 8'h40, 4'd0, acc); n++; end
    for (int i = 0; i < 30 && !seen; i++) begin
      if (loadOut[1]) begin
        seen = 1;
        checks++; if (controlOut[15:8] !== 8'h40) begin failures++; $display("FAIL jump_ctrl got=%h exp=40", controlOut[15:8]); end
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL jump_busy_clear got=%b exp=0", busy[1]); end
        checks++; if (loadOut !== 4'b0010) begin failures++; $display("FAIL jump_onehot got=%h exp=2", loadOut); end
      end else begin
        checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL jump_busy_set got=%b exp=1", busy[1]); end
      end
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (!seen) begin failures++; $display("FAIL jump_timeout got=none exp=strobe"); end
  endtask

  task automatic test_fade_up();
    logic acc;
    int n, v;
    logic [7:0] got[$];
    int exp_q[$];
    acc = 1'b0; n = 0; v = 0;
    while (v != 10) begin v = (v + 4 < 10) ? v + 4 : 10; exp_q.push_back(v); end
    while (!acc && n < 20) begin step(1'b1, 2'd2, 8'h0A, 4'd4, acc); n++; end
    for (int i = 0; i < 60; i++) begin
      if (loadOut[2]) got.push_back(controlOut[23:16]);
      if (got.size() == 0 || got[got.size()-1] != 8'd10) begin
        checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL up_busy k=%0d got=%b exp=1", m_k, busy[2]); end
      end
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL up_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== 8'(exp_q[i])) begin failures++; $display("FAIL up_value[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL up_busy_final got=%b exp=0", busy[2]); end
  endtask

  task automatic test_fade_down();
    logic acc;
    bit seen;
    int n, v;
    logic [7:0] got[$];
    int exp_q[$];
    acc = 1'b0; n = 0; seen = 0; v = 255;
    while (v != 3) begin v = (v - 15 > 3) ? v - 15 : 3; exp_q.push_back(v); end
    while (!acc && n < 20) begin step(1'b1, 2'd0, 8'hFF, 4'd0, acc); n++; end
    for (int i = 0; i < 30 && !seen; i++) begin
      if (loadOut[0]) begin
        seen = 1;
        checks++; if (controlOut[7:0] !== shape(255)) begin failures++; $display("FAIL down_start got=%h exp=%h", controlOut[7:0], shape(255)); end
      end
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (!seen) begin failures++; $display("FAIL down_start_timeout got=none exp=strobe"); end
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin step(1'b1, 2'd0, 8'h03, 4'd15, acc); n++; end
    for (int i = 0; i < 220; i++) begin
      if (loadOut[0]) got.push_back(controlOut[7:0]);
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL down_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== shape(exp_q[i])) begin failures++; $display("FAIL down_value[%0d] got=%h exp=%h", i, got[i], shape(exp_q[i])); end
    end
  endtask

  task automatic test_ready_blocking();
    logic acc;
    bit seen;
    int n, ph;
    n = 0; acc = 1'b0; seen = 0;
    while ((m_k % STEP) != STEP - 1 && n < 20) begin step(1'b0, 2'd0, 8'h0, 4'h0, acc); n++; end
    while (!acc && n < 40) begin
      ph = m_k % STEP;
      checks++;
      if (ifc.reqReady !== m_ready()) begin failures++; $display("FAIL block_ready phase=%0d got=%b exp=%b", ph, ifc.reqReady, m_ready()); end
      step(1'b1, 2'd3, 8'h55, 4'd0, acc);
      n++;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      if (loadOut[3]) begin
        seen = 1;
        checks++; if (controlOut[31:24] !== shape(8'h55)) begin failures++; $display("FAIL block_ctrl got=%h exp=%h", controlOut[31:24], shape(8'h55)); end
      end
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (!seen) begin failures++; $display("FAIL block_accept_timeout got=none exp=strobe"); end
  endtask

  task automatic test_reset_midscan();
    logic acc;
    int n;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    checks++; if (loadOut !== 4'b0010) begin failures++; $display("FAIL mid_ch1_strobe got=%h exp=2", loadOut); end
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (loadOut !== m_load) begin failures++; $display("FAIL mid_load k=%0d got=%h exp=%h", m_k, loadOut, m_load); end
      checks++; if (controlOut !== 32'h0) begin failures++; $display("FAIL mid_ctrl k=%0d got=%h exp=0", m_k, controlOut); end
      n += $countones(loadOut);
      step(1'b0, 2'd0, 8'h0, 4'h0, acc);
    end
    checks++; if (n != 4) begin failures++; $display("FAIL mid_reinit_count got=%0d exp=4", n); end
  endtask

  task automatic test_random();
    logic acc;
    logic v;
    logic [1:0] ch;
    logic [7:0] t;
    logic [3:0] r;
    for (int i = 0; i < 400; i++) begin
      checks++; if (loadOut !== m_load) begin failures++; $display("FAIL rnd_load k=%0d got=%h exp=%h", m_k, loadOut, m_load); end
      checks++; if (controlOut !== exp_ctrl()) begin failures++; $display("FAIL rnd_ctrl k=%0d got=%h exp=%h", m_k, controlOut, exp_ctrl()); end
      checks++; if (busy !== exp_busy()) begin failures++; $display("FAIL rnd_busy k=%0d got=%h exp=%h", m_k, busy, exp_busy()); end
      checks++; if (ifc.reqReady !== m_ready()) begin failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", m_k, ifc.reqReady, m_ready()); end
      checks++; if ($countones(loadOut) > 1) begin failures++; $display("FAIL rnd_onehot k=%0d got=%h exp=<=1 bit", m_k, loadOut); end
      v  = ($urandom_range(0, 3) == 0);
      ch = 2'($urandom_range(0, 3));
      t  = 8'($urandom_range(0, 255));
      r  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(v, ch, t, r, acc);
    end
  endtask

  initial begin
    ifc.reqValid   = 1'b0;
    ifc.reqChannel = '0;
    ifc.reqTarget  = '0;
    ifc.reqRate    = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_jump();
    test_fade_up();
    test_fade_down();
    test_ready_blocking();
    test_reset_midscan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
